// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory fetch unit: fill word,
// controller states and fault-bit positions.
package imem_pkg;

  // addi x0,x0,0 -- fill value and the word returned on any fetch fault
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  // Bit positions inside the 2-bit fetch fault vector
  localparam int FAULT_MISALIGN = 0;
  localparam int FAULT_RANGE    = 1;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    READY = 2'd1,
    PROG  = 2'd2
  } state_e;

endpackage

// File: rtl/imem_sram_1r1w.sv
// XLEN x DEPTH storage array with one synchronous write port and one
// registered read port, shaped so synthesis can map it onto block RAM.
module imem_sram_1r1w #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic            i_clk,
  input  logic            i_we,
  input  logic [AW-1:0]   i_waddr,
  input  logic [XLEN-1:0] i_wdata,
  input  logic            i_re,
  input  logic [AW-1:0]   i_raddr,
  output logic [XLEN-1:0] o_rdata
);

  logic [XLEN-1:0] r_mem [DEPTH];
  logic [XLEN-1:0] r_rdata;

  // Write port: one word per cycle when enabled
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Read port: output register only updates on an enabled read, so the
  // last fetched word stays visible between reads
  always_ff @(posedge i_clk) begin
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/imem_fetch_unit.sv
// Instruction memory front end: post-reset NOP clear sweep, runtime
// programming port and a one-cycle registered fetch port with fault flags.
module imem_fetch_unit #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 256,
  parameter logic [XLEN-1:0] NOP_WORD = XLEN'(imem_pkg::NOP_WORD)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            fetch_req,
  input  logic [XLEN-1:0] fetch_addr,
  output logic            fetch_ready,
  output logic            fetch_valid,
  output logic [XLEN-1:0] fetch_instr,
  output logic [1:0]      fetch_fault,
  input  logic            prog_en,
  input  logic            prog_we,
  input  logic [XLEN-1:0] prog_addr,
  input  logic [XLEN-1:0] prog_data,
  output logic            prog_err,
  input  logic            clear_req,
  output logic            busy
);

  import imem_pkg::*;

  localparam int            AW        = $clog2(DEPTH);
  // One bit wider than the address so the limit itself is representable
  // and the compare never wraps.
  localparam logic [XLEN:0] RANGE_LIM = (XLEN+1)'(DEPTH * 4);

  state_e          r_state;
  logic [AW-1:0]   r_ptr;
  logic            r_valid;
  logic [1:0]      r_fault;
  logic            r_nop_sel;
  logic            r_prog_err;

  logic            w_fetch_ready;
  logic            w_accept;
  logic [1:0]      w_fetch_fault;
  logic [1:0]      w_prog_fault;
  logic            w_prog_wr;
  logic            w_prog_bad;
  logic            w_mem_we;
  logic            w_mem_re;
  logic [AW-1:0]   w_mem_waddr;
  logic [XLEN-1:0] w_mem_wdata;
  logic [XLEN-1:0] w_mem_rdata;

  // Misaligned when either low byte-offset bit is set; out of range when
  // the full byte address reaches the end of the array.
  function automatic logic [1:0] addr_fault(input logic [XLEN-1:0] a);
    logic [1:0] f;
    f                 = '0;
    f[FAULT_MISALIGN] = (a[1:0] != 2'b00);
    f[FAULT_RANGE]    = ({1'b0, a} >= RANGE_LIM);
    return f;
  endfunction

  assign w_fetch_fault = addr_fault(fetch_addr);
  assign w_prog_fault  = addr_fault(prog_addr);

  assign w_fetch_ready = (r_state == READY) && !prog_en;
  assign w_accept      = fetch_req && w_fetch_ready;
  // Faulting fetches never touch the array
  assign w_mem_re      = w_accept && (w_fetch_fault == 2'b00);

  assign w_prog_wr     = (r_state == PROG) && prog_en && prog_we;
  assign w_prog_bad    = w_prog_wr && (w_prog_fault != 2'b00);

  assign w_mem_we      = (r_state == CLEAR) || (w_prog_wr && !w_prog_bad);
  assign w_mem_waddr   = (r_state == CLEAR) ? r_ptr : prog_addr[AW+1:2];
  assign w_mem_wdata   = (r_state == CLEAR) ? NOP_WORD : prog_data;

  imem_sram_1r1w #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_sram (
    .i_clk   (clk),
    .i_we    (w_mem_we),
    .i_waddr (w_mem_waddr),
    .i_wdata (w_mem_wdata),
    .i_re    (w_mem_re),
    .i_raddr (fetch_addr[AW+1:2]),
    .o_rdata (w_mem_rdata)
  );

  // Controller: state, sweep pointer and registered response/error flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= CLEAR;
      r_ptr      <= '0;
      r_valid    <= 1'b0;
      r_fault    <= 2'b00;
      r_nop_sel  <= 1'b1;
      r_prog_err <= 1'b0;
    end else begin
      r_valid    <= w_accept;
      r_prog_err <= w_prog_bad;
      if (w_accept) begin
        r_fault   <= w_fetch_fault;
        r_nop_sel <= (w_fetch_fault != 2'b00);
      end
      case (r_state)
        CLEAR: begin
          r_ptr <= r_ptr + 1'b1;
          if (r_ptr == AW'(DEPTH - 1)) r_state <= READY;
        end
        READY: begin
          if (clear_req) begin
            r_state <= CLEAR;
            r_ptr   <= '0;
          end else if (prog_en) begin
            r_state <= PROG;
          end
        end
        PROG: begin
          if (clear_req) begin
            r_state <= CLEAR;
            r_ptr   <= '0;
          end else if (!prog_en) begin
            r_state <= READY;
          end
        end
        default: r_state <= CLEAR;
      endcase
    end
  end

  assign fetch_ready = w_fetch_ready;
  assign fetch_valid = r_valid;
  assign fetch_fault = r_fault;
  // Faulted responses and the post-reset value show the fill word; the
  // RAM output register is not reset, so it is masked here instead.
  assign fetch_instr = r_nop_sel ? NOP_WORD : w_mem_rdata;
  assign prog_err    = r_prog_err;
  assign busy        = (r_state == CLEAR);

endmodule
